max_score_tracker: RTL and testbench

- Sits directly downstream of the PU array's registered score outputs, in parallel with the matrix memory.
- Each cycle it takes the 2x2 score tiles of all PUs and reduces them through a 3-stage pipeline.
- It keeps the running maximum score and that score's (row, col) cell coordinate for the current alignment.
- At end of fill it reports the result to the traceback controller with a one-cycle done pulse.

---
 rtl/max_score_tracker.sv | 160 ++++++++++++++++
 tb/tb_max_score_tracker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/max_score_tracker.sv
// Running maximum score tracker: reduces per-PU 2x2 score tiles through a
// 3-stage pipeline and reports the best (score, row, col) with a done pulse.
module max_score_tracker #(
    parameter int NUM_PU       = 4,
    parameter int NUM_ROWS_PE  = 2,
    parameter int NUM_COLS_PE  = 2,
    parameter int SCORE_WIDTH  = 10,
    parameter int SEQ_LENGTH_W = 5
) (
    input  logic                                                        clk,
    input  logic                                                        rst,
    input  logic                                                        start,
    input  logic [NUM_PU-1:0][NUM_ROWS_PE-1:0][NUM_COLS_PE-1:0][SCORE_WIDTH-1:0] scores_in,
    input  logic [NUM_PU-1:0]                                           valid_pu,
    input  logic [NUM_PU-1:0][SEQ_LENGTH_W-1:0]                         row_base,
    input  logic [NUM_PU-1:0][SEQ_LENGTH_W-1:0]                         col_base,
    input  logic                                                        last,
    output logic                                                        busy,
    output logic                                                        done,
    output logic [SCORE_WIDTH-1:0]                                      max_score,
    output logic [SEQ_LENGTH_W-1:0]                                     max_row,
    output logic [SEQ_LENGTH_W-1:0]                                     max_col
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] drain_cnt;
    logic       clear;

    // Per-PU tile reduction (combinational front of stage 1)
    logic [NUM_PU-1:0][SCORE_WIDTH-1:0]  t_score;
    logic [NUM_PU-1:0][SEQ_LENGTH_W-1:0] t_row, t_col;

    logic [NUM_PU-1:0][SCORE_WIDTH-1:0]  s1_score;
    logic [NUM_PU-1:0][SEQ_LENGTH_W-1:0] s1_row, s1_col;
    logic [NUM_PU-1:0]                   s1_valid;

    // Cross-PU reduction (combinational front of stage 2)
    logic [SCORE_WIDTH-1:0]  b_score;
    logic [SEQ_LENGTH_W-1:0] b_row, b_col;
    logic                    b_found;

    logic [SCORE_WIDTH-1:0]  s2_score;
    logic [SEQ_LENGTH_W-1:0] s2_row, s2_col;
    logic                    s2_valid;

    assign clear = (state == IDLE) && start;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its sources, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DRAIN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   drain_cnt <= 2'd0;
        else if (state == RUN && last)             drain_cnt <= 2'd2;
        else if (state == DRAIN && drain_cnt != 0) drain_cnt <= drain_cnt - 2'd1;
    end

    // Scan order (j, k) ascending with strict '>' keeps the lowest j, then k, on ties.
    always_comb begin
        for (int i = 0; i < NUM_PU; i++) begin
            t_score[i] = scores_in[i][0][0];
            t_row[i]   = row_base[i];
            t_col[i]   = col_base[i];
            for (int j = 0; j < NUM_ROWS_PE; j++) begin
                for (int k = 0; k < NUM_COLS_PE; k++) begin
                    if (scores_in[i][j][k] > t_score[i]) begin
                        t_score[i] = scores_in[i][j][k];
                        t_row[i]   = row_base[i] + SEQ_LENGTH_W'(j);
                        t_col[i]   = col_base[i] + SEQ_LENGTH_W'(k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_score <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_valid <= '0;
        end else begin
            s1_score <= t_score;
            s1_row   <= t_row;
            s1_col   <= t_col;
            s1_valid <= (state == RUN) ? valid_pu : '0;
        end
    end

    // First valid PU is taken unconditionally so a valid all-zero beat still resolves.
    always_comb begin
        b_score = '0;
        b_row   = '0;
        b_col   = '0;
        b_found = 1'b0;
        for (int i = 0; i < NUM_PU; i++) begin
            if (s1_valid[i] && (!b_found || s1_score[i] > b_score)) begin
                b_score = s1_score[i];
                b_row   = s1_row[i];
                b_col   = s1_col[i];
                b_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_score <= '0;
            s2_row   <= '0;
            s2_col   <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_score <= b_score;
            s2_row   <= b_row;
            s2_col   <= b_col;
            s2_valid <= clear ? 1'b0 : b_found;
        end
    end

    // Strictly greater keeps the earliest beat on cross-beat ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_score <= '0;
            max_row   <= '0;
            max_col   <= '0;
        end else if (clear) begin
            max_score <= '0;
            max_row   <= '0;
            max_col   <= '0;
        end else if (s2_valid && s2_score > max_score) begin
            max_score <= s2_score;
            max_row   <= s2_row;
            max_col   <= s2_col;
        end
    end

endmodule

// File: tb/tb_max_score_tracker.sv
// Directed self-checking bench for max_score_tracker.
module tb_max_score_tracker;

    localparam int NUM_PU = 4;
    localparam int SW     = 10;
    localparam int CW     = 5;

    logic                                 clk = 1'b0;
    logic                                 rst;
    logic                                 start;
    logic [NUM_PU-1:0][1:0][1:0][SW-1:0]  scores_in;
    logic [NUM_PU-1:0]                    valid_pu;
    logic [NUM_PU-1:0][CW-1:0]            row_base;
    logic [NUM_PU-1:0][CW-1:0]            col_base;
    logic                                 last;
    logic                                 busy;
    logic                                 done;
    logic [SW-1:0]                        max_score;
    logic [CW-1:0]                        max_row;
    logic [CW-1:0]                        max_col;

    int n_vec = 0;
    int n_err = 0;

    max_score_tracker #(
        .NUM_PU(NUM_PU), .NUM_ROWS_PE(2), .NUM_COLS_PE(2),
        .SCORE_WIDTH(SW), .SEQ_LENGTH_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .scores_in(scores_in),
        .valid_pu(valid_pu), .row_base(row_base), .col_base(col_base),
        .last(last), .busy(busy), .done(done), .max_score(max_score),
        .max_row(max_row), .max_col(max_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start     = 1'b0;
        last      = 1'b0;
        scores_in = '0;
        valid_pu  = '0;
        row_base  = '0;
        col_base  = '0;
    endtask

    task automatic set_tile(input int pu, input int s00, input int s01, input int s10,
                            input int s11, input int rb, input int cb);
        scores_in[pu][0][0] = SW'(s00);
        scores_in[pu][0][1] = SW'(s01);
        scores_in[pu][1][0] = SW'(s10);
        scores_in[pu][1][1] = SW'(s11);
        row_base[pu]        = CW'(rb);
        col_base[pu]        = CW'(cb);
    endtask

    task automatic check_result(input string tag, input int s, input int r, input int c);
        check({tag, " score"}, 32'(max_score), 32'(s));
        check({tag, " row"},   32'(max_row),   32'(r));
        check({tag, " col"},   32'(max_col),   32'(c));
    endtask

    // Steps until done rises (bounded); latency counted from the edge that sampled last.
    task automatic wait_done(input string tag, input int exp_cycles);
        int n = 0;
        while (done !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check({tag, " done latency"}, 32'(n), 32'(exp_cycles));
    endtask

    task automatic do_start();
        clear_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check_result("reset", 0, 0, 0);
        rst = 1'b0;

        // 1: reset mid-RUN after a 37 beat
        do_start();
        check("t1 busy after start", 32'(busy), 1);
        set_tile(0, 37, 1, 2, 3, 3, 2);
        valid_pu = 4'b0001;
        step();
        clear_inputs();
        step();
        step();
        check_result("t1 pre-reset", 37, 3, 2);
        rst = 1'b1;
        #1;
        check_result("t1 async reset", 0, 0, 0);
        check("t1 busy in reset", 32'(busy), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1 no done after abort", 32'(done), 0);
            check("t1 idle after abort", 32'(busy), 0);
        end

        // 2: single beat with a tie inside the tile, exact latency
        do_start();
        set_tile(2, 5, 9, 9, 3, 4, 6);
        valid_pu = 4'b1111;
        last     = 1'b1;
        step();
        clear_inputs();
        check("t2 busy in drain", 32'(busy), 1);
        check("t2 done T+0", 32'(done), 0);
        step();
        check("t2 done T+1", 32'(done), 0);
        step();
        check("t2 done T+2", 32'(done), 0);
        check_result("t2 early", 9, 4, 7);
        step();
        check("t2 done T+3", 32'(done), 1);
        check("t2 busy in done", 32'(busy), 0);
        check_result("t2 final", 9, 4, 7);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t2 done one cycle", 32'(done), 0);
        check("t2 start with done ignored", 32'(busy), 0);
        step();
        check("t2 still idle", 32'(busy), 0);
        check_result("t2 hold in idle", 9, 4, 7);

        // 3: 12, 20, 20 across beats -> earlier 20 kept
        do_start();
        check_result("t3 cleared by start", 0, 0, 0);
        set_tile(0, 1, 2, 3, 12, 1, 1);
        valid_pu = 4'b0001;
        step();
        clear_inputs();
        set_tile(1, 20, 4, 4, 4, 5, 8);
        valid_pu = 4'b0010;
        step();
        clear_inputs();
        set_tile(3, 7, 7, 20, 7, 10, 12);
        valid_pu = 4'b1000;
        last     = 1'b1;
        step();
        clear_inputs();
        wait_done("t3", 3);
        check_result("t3", 20, 5, 8);
        step();

        // 4: invalid PU0 with the larger score is ignored
        do_start();
        set_tile(0, 50, 0, 0, 0, 1, 1);
        set_tile(1, 0, 0, 0, 40, 6, 2);
        valid_pu = 4'b0010;
        last     = 1'b1;
        step();
        clear_inputs();
        wait_done("t4", 3);
        check_result("t4", 40, 7, 3);
        step();

        // 5: cross-PU tie -> lowest PU; start alongside last is ignored
        do_start();
        set_tile(1, 0, 33, 0, 0, 2, 4);
        set_tile(3, 33, 0, 0, 0, 8, 9);
        valid_pu = 4'b1111;
        last     = 1'b1;
        start    = 1'b1;
        step();
        clear_inputs();
        wait_done("t5", 3);
        check_result("t5", 33, 2, 5);
        step();

        // 6: all-zero beats, empty last beat, start during DRAIN ignored
        do_start();
        for (int b = 0; b < 8; b++) begin
            for (int p = 0; p < NUM_PU; p++) set_tile(p, 0, 0, 0, 0, b + 1, p + 2);
            valid_pu = 4'b1111;
            step();
        end
        clear_inputs();
        last = 1'b1;
        step();
        clear_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6 busy after drain start", 32'(busy), 1);
        step();
        check("t6 busy before done", 32'(busy), 1);
        check("t6 done not yet", 32'(done), 0);
        wait_done("t6", 1);
        check_result("t6", 0, 0, 0);
        step();
        check("t6 back to idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
